// File: rtl/apu_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apu_frame_sequencer_if                                                   |
// | CPU-side register/strobe bus and frame outputs of the APU frame counter. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface apu_frame_sequencer_if;
  logic       cpu_clock;
  logic       apu_cs;
  logic [4:0] ioreg_addr;
  logic [7:0] ioreg_datain;
  logic       ioreg_wr;
  logic       status_rd;
  logic       frame_e;
  logic       frame_l;
  logic       frame_irq;
  logic       mode_5step;

  modport master (
    output cpu_clock, apu_cs, ioreg_addr, ioreg_datain, ioreg_wr, status_rd,
    input  frame_e, frame_l, frame_irq, mode_5step
  );

  modport slave (
    input  cpu_clock, apu_cs, ioreg_addr, ioreg_datain, ioreg_wr, status_rd,
    output frame_e, frame_l, frame_irq, mode_5step
  );
endinterface
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apu_frame_sequencer                                                      |
// | APU frame counter: quarter/half-frame strobes, $4017 mode/inhibit and    |
// | the frame IRQ flag.                                                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module apu_frame_sequencer #(
  // The 5-step sequence runs to 37282, so the count and step constants are 16 bits wide.
  parameter logic [15:0] STEP1      = 16'd7457,
  parameter logic [15:0] STEP2      = 16'd14913,
  parameter logic [15:0] STEP3      = 16'd22371,
  parameter logic [15:0] STEP4      = 16'd29829,
  parameter logic [15:0] STEP5      = 16'd37281,
  parameter logic [4:0]  REG17_ADDR = 5'h17
) (
  input wire                   sysclk,
  input wire                   reset,
  apu_frame_sequencer_if.slave bus
);

  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_pending;
  logic        r_phase;
  logic        r_mode;
  logic        r_inhibit;
  logic        r_irq;
  logic        r_frame_e;
  logic        r_frame_l;

  logic        w_tick;
  logic        w_wr17;
  logic        w_fire;
  logic        w_wrap;
  logic        w_irq_win;
  logic        w_ev_e;
  logic        w_ev_l;
  logic        w_unused_data;

  assign w_tick        = bus.cpu_clock;
  assign w_wr17        = w_tick & bus.apu_cs & bus.ioreg_wr & (bus.ioreg_addr == REG17_ADDR);
  // A fresh $4017 write on the expiry tick restarts the delay instead of firing.
  assign w_fire        = w_tick & (r_pending == 3'd1) & ~w_wr17;
  assign w_wrap        = r_mode ? (r_cycle_cnt >= STEP5 + 16'd1)
                                : (r_cycle_cnt >= STEP4 + 16'd1);
  assign w_irq_win     = ~r_mode & ~r_inhibit &
                         (r_cycle_cnt >= STEP4 - 16'd1) & (r_cycle_cnt <= STEP4 + 16'd1);
  assign w_unused_data = ^bus.ioreg_datain[5:0];

  always_comb begin
    w_ev_e = 1'b0;
    w_ev_l = 1'b0;
    if ((r_cycle_cnt == STEP1) || (r_cycle_cnt == STEP3)) begin
      w_ev_e = 1'b1;
    end
    if (r_cycle_cnt == STEP2) begin
      w_ev_e = 1'b1;
      w_ev_l = 1'b1;
    end
    if ((!r_mode && (r_cycle_cnt == STEP4)) || (r_mode && (r_cycle_cnt == STEP5))) begin
      w_ev_e = 1'b1;
      w_ev_l = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_cycle_cnt <= 16'd0;
      r_pending   <= 3'd0;
      r_phase     <= 1'b0;
      r_mode      <= 1'b0;
      r_inhibit   <= 1'b0;
      r_irq       <= 1'b0;
      r_frame_e   <= 1'b0;
      r_frame_l   <= 1'b0;
    end else begin
      // The delayed sequencer restart replaces the normal step events of its tick.
      r_frame_e <= w_tick & (w_fire ? r_mode : w_ev_e);
      r_frame_l <= w_tick & (w_fire ? r_mode : w_ev_l);

      if (w_tick) begin
        r_phase <= ~r_phase;
        if (w_fire || w_wrap) begin
          r_cycle_cnt <= 16'd0;
        end else begin
          r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
      end

      if (w_wr17) begin
        r_mode    <= bus.ioreg_datain[7];
        r_inhibit <= bus.ioreg_datain[6];
        r_pending <= r_phase ? 3'd3 : 3'd4;
      end else if (w_tick && (r_pending != 3'd0)) begin
        r_pending <= r_pending - 3'd1;
      end

      // Inhibit write clears outright; otherwise a window hit beats a status read.
      if (w_wr17 && bus.ioreg_datain[6]) begin
        r_irq <= 1'b0;
      end else if (w_tick && w_irq_win) begin
        r_irq <= 1'b1;
      end else if (w_tick && bus.status_rd) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign bus.frame_e    = r_frame_e;
  assign bus.frame_l    = r_frame_l;
  assign bus.frame_irq  = r_irq;
  assign bus.mode_5step = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apu_frame_sequencer                                                   |
// | Scoreboard bench for the APU frame counter on shortened step constants.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_apu_frame_sequencer;

  localparam int c_S1         = 745;
  localparam int c_S2         = 1491;
  localparam int c_S3         = 2237;
  localparam int c_S4         = 2982;
  localparam int c_S5         = 3728;
  localparam int c_P4         = c_S4 + 2;
  localparam int c_P5         = c_S5 + 2;
  localparam int c_MAX_CYCLES = 60000;

  logic sysclk = 1'b0;
  logic reset;

  apu_frame_sequencer_if bus ();

  apu_frame_sequencer #(
    .STEP1      (16'(c_S1)),
    .STEP2      (16'(c_S2)),
    .STEP3      (16'(c_S3)),
    .STEP4      (16'(c_S4)),
    .STEP5      (16'(c_S5)),
    .REG17_ADDR (5'h17)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int         n_vec     = 0;
  int         n_err     = 0;
  int         cyc_count = 0;
  logic [3:0] exp_q[$];

  // Reference state: counter position is derived from the tick index and a period origin.
  int m_tick    = 0;
  int m_origin  = 0;
  int m_fire_at = -1;
  bit m_mode    = 1'b0;
  bit m_inh     = 1'b0;
  bit m_irq     = 1'b0;

  int obs_e     = 0;
  int obs_l     = 0;
  bit irq_seen  = 1'b0;
  int irq_rise  = -1;
  bit prev_irq  = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_obs();
    obs_e    = 0;
    obs_l    = 0;
    irq_seen = 1'b0;
  endtask

  task automatic cycle(input bit rst, input bit tk, input bit wr, input logic [4:0] addr,
                       input logic [7:0] din, input bit srd);
    int         t;
    int         per;
    int         cnt;
    bit         e;
    bit         l;
    bit         wr17;
    logic [3:0] got;
    logic [3:0] exp;
    cyc_count++;
    if (cyc_count > c_MAX_CYCLES) begin
      n_vec++;
      n_err++;
      $display("FAIL cycle_budget: got %0d expected at most %0d", cyc_count, c_MAX_CYCLES);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "cycle budget exhausted");
    end
    reset            = rst;
    bus.cpu_clock    = tk;
    bus.apu_cs       = wr;
    bus.ioreg_wr     = wr;
    bus.ioreg_addr   = addr;
    bus.ioreg_datain = din;
    bus.status_rd    = srd;

    e    = 1'b0;
    l    = 1'b0;
    t    = m_tick;
    wr17 = wr && (addr == 5'h17);
    if (rst) begin
      m_tick    = 0;
      m_origin  = 0;
      m_fire_at = -1;
      m_mode    = 1'b0;
      m_inh     = 1'b0;
      m_irq     = 1'b0;
    end else if (tk) begin
      per      = m_mode ? c_P5 : c_P4;
      cnt      = (t - m_origin) % per;
      m_origin = t - cnt;
      if (t == m_fire_at) begin
        e         = m_mode;
        l         = m_mode;
        m_origin  = t + 1;
        m_fire_at = -1;
      end else begin
        e = (cnt == c_S1) || (cnt == c_S2) || (cnt == c_S3) || (cnt == (m_mode ? c_S5 : c_S4));
        l = (cnt == c_S2) || (cnt == (m_mode ? c_S5 : c_S4));
      end
      if (wr17 && din[6]) m_irq = 1'b0;
      else if (!m_mode && !m_inh && cnt >= c_S4 - 1 && cnt <= c_S4 + 1) m_irq = 1'b1;
      else if (srd) m_irq = 1'b0;
      if (wr17) begin
        m_mode    = din[7];
        m_inh     = din[6];
        m_fire_at = t + ((t % 2 == 1) ? 3 : 4);
      end
      m_tick++;
    end
    exp_q.push_back({e, l, m_irq, m_mode});

    @(posedge sysclk);
    #1;
    got = {bus.frame_e, bus.frame_l, bus.frame_irq, bus.mode_5step};
    exp = exp_q.pop_front();
    chk_eq($sformatf("outs t=%0d", t), 32'(got), 32'(exp));
    if (!rst && tk) begin
      if (bus.frame_e) obs_e++;
      if (bus.frame_l) obs_l++;
      if (bus.frame_irq) irq_seen = 1'b1;
      if (bus.frame_irq && !prev_irq && irq_rise < 0) irq_rise = t;
    end
    prev_irq = bus.frame_irq;
  endtask

  task automatic tick_op(input bit wr, input logic [4:0] addr, input logic [7:0] din,
                         input bit srd);
    cycle(1'b0, 1'b1, wr, addr, din, srd);
  endtask

  // Gap cycles carry unqualified writes and status reads that must be ignored.
  task automatic run_to(input int n);
    while (m_tick < n) begin
      if ($urandom_range(0, 7) == 0) cycle(1'b0, 1'b0, 1'b1, 5'h17, 8'hC0, ($urandom_range(0, 1) == 1));
      else cycle(1'b0, 1'b1, 1'b0, 5'h17, 8'h00, 1'b0);
    end
  endtask

  initial begin
    int t_w;
    int o;
    int t4;
    int o4;
    int t5;
    int t6;
    int o6;
    int t7;

    reset            = 1'b1;
    bus.cpu_clock    = 1'b0;
    bus.apu_cs       = 1'b0;
    bus.ioreg_wr     = 1'b0;
    bus.ioreg_addr   = 5'h00;
    bus.ioreg_datain = 8'h00;
    bus.status_rd    = 1'b0;

    repeat (3) cycle(1'b1, 1'b1, 1'b1, 5'h17, 8'hC0, 1'b0);
    chk_eq("reset_outs", {bus.frame_e, bus.frame_l, bus.frame_irq, bus.mode_5step}, 4'b0000);

    // 4-step from reset: pulse schedule, IRQ window, status read behaviour.
    clr_obs();
    run_to(100);
    tick_op(1'b1, 5'h16, 8'h40, 1'b0);
    run_to(c_S4);
    tick_op(1'b0, 5'h15, 8'h00, 1'b1);
    chk_eq("irq_set_beats_read", bus.frame_irq, 1);
    chk_eq("irq_rise_tick", irq_rise, c_S4 - 1);
    run_to(c_P4);
    chk_eq("4step_e_count", obs_e, 4);
    chk_eq("4step_l_count", obs_l, 2);
    run_to(c_P4 + 4);
    tick_op(1'b0, 5'h15, 8'h00, 1'b1);
    chk_eq("irq_read_clear", bus.frame_irq, 0);

    // Switch to 5-step on an odd tick: restart 3 ticks later with e+l.
    t_w = c_P4 + 17;
    run_to(t_w);
    tick_op(1'b1, 5'h17, 8'h80, 1'b0);
    chk_eq("mode_immediate", bus.mode_5step, 1);
    run_to(t_w + 3);
    tick_op(1'b0, 5'h17, 8'h00, 1'b0);
    chk_eq("5step_restart_el", {bus.frame_e, bus.frame_l}, 2'b11);
    o = t_w + 4;
    clr_obs();
    run_to(o + c_P5);
    chk_eq("5step_e_count", obs_e, 4);
    chk_eq("5step_l_count", obs_l, 2);
    chk_eq("5step_no_irq", irq_seen, 0);

    // Back to 4-step on an even tick: silent restart 4 ticks later.
    t4 = o + c_P5 + 20;
    if (t4 % 2 == 1) t4++;
    run_to(t4);
    tick_op(1'b1, 5'h17, 8'h00, 1'b0);
    clr_obs();
    run_to(t4 + 6);
    chk_eq("4step_restart_silent", obs_e + obs_l, 0);
    o4       = t4 + 5;
    irq_rise = -1;
    run_to(o4 + c_S4 + 6);
    chk_eq("irq_rise_after_restart", irq_rise, o4 + c_S4 - 1);

    // Inhibit write clears the flag and keeps it clear for two periods.
    t5 = o4 + c_S4 + 6;
    tick_op(1'b1, 5'h17, 8'h40, 1'b0);
    chk_eq("irq_inhibit_clear", bus.frame_irq, 0);
    clr_obs();
    run_to(t5 + 2 * c_P4 + 10);
    chk_eq("inhibit_no_irq", irq_seen, 0);
    chk_eq("inhibit_e_count", obs_e, 8);
    chk_eq("inhibit_l_count", obs_l, 4);

    // Reset while a 5-step restart is pending and the flag is set.
    t6 = m_tick;
    tick_op(1'b1, 5'h17, 8'h00, 1'b0);
    o6 = t6 + ((t6 % 2 == 1) ? 3 : 4) + 1;
    run_to(o6 + c_S4);
    chk_eq("irq_before_reset", bus.frame_irq, 1);
    t7 = o6 + c_P4;
    if (t7 % 2 == 1) t7++;
    run_to(t7);
    tick_op(1'b1, 5'h17, 8'h80, 1'b0);
    tick_op(1'b0, 5'h17, 8'h00, 1'b0);
    tick_op(1'b0, 5'h17, 8'h00, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 5'h17, 8'hC0, 1'b0);
    chk_eq("reset_mid_outs", {bus.frame_e, bus.frame_l, bus.frame_irq, bus.mode_5step}, 4'b0000);
    clr_obs();
    run_to(c_S1 + 4);
    chk_eq("post_reset_e_count", obs_e, 1);
    chk_eq("post_reset_l_count", obs_l, 0);
    chk_eq("post_reset_mode", bus.mode_5step, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
